// File: rtl/btn_cond.sv
// Push-button front end: 2-flop synchroniser, tick-sampled debounce, one-cycle press
// pulses, and auto-repeat on ADJUST while the button is held.
module btn_cond #(
    parameter int SAMPLE_DIV = 250000,
    parameter int DEB_CNT    = 4,
    parameter int RPT_DELAY  = 100,
    parameter int RPT_RATE   = 25
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] BTN,
    output logic       MODE,
    output logic       SELECT,
    output logic       ADJUST
);
    localparam int PW      = $clog2(SAMPLE_DIV);
    localparam int DW      = $clog2(DEB_CNT + 1);
    localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int RW      = $clog2(RPT_MAX + 1);

    localparam logic [PW-1:0] DIV_LAST   = PW'(SAMPLE_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CNT - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(RPT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(RPT_RATE - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_t;

    logic [2:0]    sync1, sync2;
    logic [PW-1:0] div_cnt;
    logic          tick;
    logic [DW-1:0] deb_cnt [3];
    logic [2:0]    stable;
    logic [2:0]    flip;
    logic [2:0]    rise;
    logic          adj_fall;
    rpt_state_t    state;
    logic [RW-1:0] rpt_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= BTN;
            sync2 <= sync1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) div_cnt <= '0;
        else     div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    // A channel's stable level flips on the tick that completes DEB_CNT mismatching samples.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            flip[i] = tick && (sync2[i] != stable[i]) && (deb_cnt[i] == DEB_LAST);
        end
    end

    assign rise     = flip & ~stable;
    assign adj_fall = flip[2] & stable[2];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stable <= '0;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else if (tick) begin
            stable <= stable ^ flip;
            for (int i = 0; i < 3; i++) begin
                if ((sync2[i] == stable[i]) || flip[i]) deb_cnt[i] <= '0;
                else                                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
        end
    end

    // Outputs are registered; ADJUST is only ever raised on a rise or a tick, never back to back.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            MODE    <= 1'b0;
            SELECT  <= 1'b0;
            ADJUST  <= 1'b0;
            state   <= IDLE;
            rpt_cnt <= '0;
        end else begin
            MODE   <= rise[0];
            SELECT <= rise[1];
            ADJUST <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise[2]) begin
                        ADJUST  <= 1'b1;
                        state   <= HOLD;
                        rpt_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (adj_fall) begin
                        state   <= IDLE;
                        rpt_cnt <= '0;
                    end else if (tick) begin
                        if (rpt_cnt == DELAY_LAST) begin
                            ADJUST  <= 1'b1;
                            state   <= REPEAT;
                            rpt_cnt <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (adj_fall) begin
                        state   <= IDLE;
                        rpt_cnt <= '0;
                    end else if (tick) begin
                        if (rpt_cnt == RATE_LAST) begin
                            ADJUST  <= 1'b1;
                            rpt_cnt <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    rpt_cnt <= '0;
                end
            endcase
        end
    end
endmodule
